// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back stage.
// The MEM/WB bundle and its bubble value live here.
package wb_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 7;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic [REG_ADDR_W-1:0] br;
    } wb_entry_t;

    localparam wb_entry_t BUBBLE = '0;

endpackage

// File: rtl/wb_reg_file.sv
// Vector register file: one synchronous write port, two async reads.
// Entry 0 reads as zero and ignores writes.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 128,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB latch, register file commit with bypass,
// branch redirect pulse and retired-instruction counter.
module wb_stage
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [DATA_W-1:0]     Result,
    input  logic [REG_ADDR_W-1:0] RdWb,
    input  logic                  Wrenable,
    input  logic [REG_ADDR_W-1:0] BranchResultOut,
    input  logic [REG_ADDR_W-1:0] RsA,
    input  logic [REG_ADDR_W-1:0] RsB,
    output logic [DATA_W-1:0]     RegA,
    output logic [DATA_W-1:0]     RegB,
    output logic [REG_ADDR_W-1:0] WbRd,
    output logic [DATA_W-1:0]     WbData,
    output logic                  WbValid,
    output logic                  BranchTaken,
    output logic [REG_ADDR_W-1:0] BranchTarget,
    output logic [31:0]           RetiredCount
);

    wb_entry_t             lat_q;
    wb_entry_t             lat_d;
    logic                  capture;
    logic                  is_branch;
    logic                  retire;
    logic                  fresh_q;
    logic [REG_ADDR_W-1:0] target_q;
    logic [31:0]           retired_q;
    logic [DATA_W-1:0]     rf_a;
    logic [DATA_W-1:0]     rf_b;

    assign capture   = !Flush && !Stall;
    assign is_branch = BranchResultOut != ZERO_REG;
    assign retire    = capture && (Wrenable || is_branch);

    assign lat_d = '{
        data: Result,
        rd:   RdWb,
        we:   Wrenable,
        br:   BranchResultOut
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= BUBBLE;
        end else if (Flush) begin
            lat_q <= BUBBLE;
        end else if (!Stall) begin
            lat_q <= lat_d;
        end
    end

    // fresh_q marks a latch loaded this edge, so a held entry never re-pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_q   <= 1'b0;
            target_q  <= ZERO_REG;
            retired_q <= '0;
        end else begin
            fresh_q <= capture;
            if (capture && is_branch) begin
                target_q <= BranchResultOut;
            end
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign WbRd         = lat_q.rd;
    assign WbData       = lat_q.data;
    assign WbValid      = lat_q.we && (lat_q.rd != ZERO_REG);
    assign BranchTaken  = fresh_q && (lat_q.br != ZERO_REG);
    assign BranchTarget = target_q;
    assign RetiredCount = retired_q;

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (WbValid),
        .waddr   (lat_q.rd),
        .wdata   (lat_q.data),
        .raddr_a (RsA),
        .raddr_b (RsB),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    assign RegA = (WbValid && RsA == WbRd) ? WbData : rf_a;
    assign RegB = (WbValid && RsB == WbRd) ? WbData : rf_b;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios then random traffic
// against an architectural model of the register state.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        Flush;
    logic [31:0] Result;
    logic [6:0]  RdWb;
    logic        Wrenable;
    logic [6:0]  BranchResultOut;
    logic [6:0]  RsA;
    logic [6:0]  RsB;
    logic [31:0] RegA;
    logic [31:0] RegB;
    logic [6:0]  WbRd;
    logic [31:0] WbData;
    logic        WbValid;
    logic        BranchTaken;
    logic [6:0]  BranchTarget;
    logic [31:0] RetiredCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk             (clk),
        .rst             (rst),
        .Stall           (Stall),
        .Flush           (Flush),
        .Result          (Result),
        .RdWb            (RdWb),
        .Wrenable        (Wrenable),
        .BranchResultOut (BranchResultOut),
        .RsA             (RsA),
        .RsB             (RsB),
        .RegA            (RegA),
        .RegB            (RegB),
        .WbRd            (WbRd),
        .WbData          (WbData),
        .WbValid         (WbValid),
        .BranchTaken     (BranchTaken),
        .BranchTarget    (BranchTarget),
        .RetiredCount    (RetiredCount)
    );

    typedef struct {
        logic        valid;
        logic [6:0]  rd;
        logic [31:0] data;
        logic        taken;
        logic [6:0]  target;
        logic [31:0] cnt;
        logic [31:0] rega;
        logic [31:0] regb;
    } exp_t;

    exp_t exp_q[$];

    // Architectural view: a captured write is visible at once
    logic [31:0] arch [128];
    logic [31:0] m_data;
    logic [6:0]  m_rd;
    logic        m_we;
    logic [6:0]  m_target;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s,
                        input logic [31:0] res, input logic [6:0] rd,
                        input logic we, input logic [6:0] br,
                        input logic [6:0] ra, input logic [6:0] rb,
                        input logic bd);
        exp_t e;
        logic taken;
        @(negedge clk);
        rst = r;
        Flush = f;
        Stall = s;
        Result = res;
        RdWb = rd;
        Wrenable = we;
        BranchResultOut = br;
        RsA = ra;
        RsB = rb;
        if (bd) begin
            force dut.retired_q = 32'hFFFF_FFFF;
            #1;
            release dut.retired_q;
            m_cnt = 32'hFFFF_FFFF;
        end
        taken = 1'b0;
        if (r) begin
            for (int i = 0; i < 128; i++) arch[i] = '0;
            m_data = '0;
            m_rd = '0;
            m_we = 1'b0;
            m_target = '0;
            m_cnt = '0;
        end else if (f) begin
            m_data = '0;
            m_rd = '0;
            m_we = 1'b0;
        end else if (!s) begin
            m_data = res;
            m_rd = rd;
            m_we = we;
            if (br != 0) begin
                taken = 1'b1;
                m_target = br;
            end
            if (we || br != 0) m_cnt = m_cnt + 1;
            if (we && rd != 0) arch[rd] = res;
        end
        e.valid  = m_we && (m_rd != 0);
        e.rd     = m_rd;
        e.data   = m_data;
        e.taken  = taken;
        e.target = m_target;
        e.cnt    = m_cnt;
        e.rega   = arch[ra];
        e.regb   = arch[rb];
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [6:0] ra, input logic [6:0] rb);
        step(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 7'd0, ra, rb, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("WbValid", 32'(WbValid), 32'(e.valid));
                chk("BranchTaken", 32'(BranchTaken), 32'(e.taken));
                chk("BranchTarget", 32'(BranchTarget), 32'(e.target));
                chk("RetiredCount", RetiredCount, e.cnt);
                chk("RegA", RegA, e.rega);
                chk("RegB", RegB, e.regb);
                if (e.valid) begin
                    chk("WbRd", 32'(WbRd), 32'(e.rd));
                    chk("WbData", WbData, e.data);
                end
            end
        end
    end

    initial begin : driver
        logic        r, f, s, we;
        logic [6:0]  rd, br, ra, rb;
        logic [31:0] res;
        int          wait_cycles;
        for (int i = 0; i < 128; i++) arch[i] = '0;
        m_data = '0;
        m_rd = '0;
        m_we = 1'b0;
        m_target = '0;
        m_cnt = '0;
        rst = 1'b1;
        Flush = 1'b0;
        Stall = 1'b0;
        Result = '0;
        RdWb = '0;
        Wrenable = 1'b0;
        BranchResultOut = '0;
        RsA = '0;
        RsB = '0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 7'd0, 7'd5, 7'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 7'd0, 7'd5, 7'd0, 1'b0);

        step(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 7'd5, 1'b1, 7'd0,
             7'd5, 7'd5, 1'b0);
        idle(7'd5, 7'd0);
        idle(7'd5, 7'd5);

        step(1'b0, 1'b0, 1'b0, 32'h1234, 7'd0, 1'b1, 7'd0,
             7'd5, 7'd0, 1'b0);
        idle(7'd0, 7'd0);

        step(1'b0, 1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 7'd42,
             7'd5, 7'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h99, 7'd6, 1'b1, 7'd17,
                 7'd6, 7'd5, 1'b0);
        end
        idle(7'd6, 7'd5);

        step(1'b0, 1'b1, 1'b1, 32'd7, 7'd9, 1'b1, 7'd0,
             7'd9, 7'd9, 1'b0);
        idle(7'd9, 7'd0);

        step(1'b0, 1'b0, 1'b0, 32'd55, 7'd3, 1'b1, 7'd0,
             7'd3, 7'd5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 7'd0, 1'b0, 7'd0,
             7'd3, 7'd5, 1'b0);
        idle(7'd3, 7'd5);

        step(1'b0, 1'b0, 1'b0, 32'hCAFE, 7'd1, 1'b1, 7'd0,
             7'd1, 7'd0, 1'b1);
        idle(7'd1, 7'd0);

        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 59) == 0);
            f   = ($urandom_range(0, 9) == 0);
            s   = ($urandom_range(0, 4) == 0);
            we  = $urandom_range(0, 1) == 1;
            rd  = 7'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) rd = 7'($urandom_range(0, 127));
            br  = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(1, 127))
                                              : 7'd0;
            res = $urandom;
            ra  = 7'($urandom_range(0, 15));
            rb  = 7'($urandom_range(0, 15));
            step(r, f, s, res, rd, we, br, ra, rb, 1'b0);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage directly downstream of the memory stage. Latches the memory stage's `Result`, `RdWb`, `Wrenable` and `BranchResultOut` into a MEM/WB register, commits writes into the 128-entry vector-processor register file, and exposes two bypassed read ports to the decode stage. Turns a nonzero branch result into a one-cycle redirect pulse for fetch and counts retired instructions.

## Interface

- `DATA_W`, 32, register and result width
- `REG_ADDR_W`, 7, register index width (matches `RdWb` and `BranchResultOut`)
- `NUM_REGS`, 128, register count (2**REG_ADDR_W)

- `clk`  in  1  single clock, all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `Stall`  in  1  hold the MEM/WB latch
- `Flush`  in  1  load a bubble into the MEM/WB latch
- `Result`  in  DATA_W  write-back data from the memory stage
- `RdWb`  in  REG_ADDR_W  destination register from the memory stage
- `Wrenable`  in  1  write request from the memory stage
- `BranchResultOut`  in  REG_ADDR_W  branch target (0 means no branch)
- `RsA`, `RsB`  in  REG_ADDR_W  decode read indices
- `RegA`, `RegB`  out  DATA_W  read data, bypassed
- `WbRd`  out  REG_ADDR_W  latched destination
- `WbData`  out  DATA_W  latched data
- `WbValid`  out  1  latched entry performs a write
- `BranchTaken`  out  1  one-cycle redirect pulse
- `BranchTarget`  out  REG_ADDR_W  last redirect target, held
- `RetiredCount`  out  32  retired-instruction counter

## Operation

- **MEM/WB latch update, priority order:**
  - `rst` clears the latch.
  - `Flush` loads a bubble (all fields 0).
  - `Stall` holds the current contents.
  - Otherwise the latch captures the four inputs.
- **Simultaneous events:** `Flush` with `Stall` gives a bubble. `rst` overrides both.
- **Write condition:** `WbValid` = latched `Wrenable` AND latched `WbRd` != 0.
- **Register 0:** hard-wired zero. Writes to it are dropped and reads of it return 0.
- **Register file write:** occurs on every edge where `WbValid` is high. A stalled entry rewrites the same value, which is idempotent.
- **Reads:** combinational. For each port independently, if `WbValid` is high and `RsX` == `WbRd`, return `WbData`; otherwise return the register file content. `RsX` == 0 always returns 0.
- **Branch redirect:**
  - When the latch captures a nonzero `BranchResultOut` (not a stall-hold and not a flush), `BranchTaken` is 1 for exactly the next cycle.
  - `BranchTarget` loads that value and holds it until the next capture of a branch.
  - A held stalled entry does not re-pulse `BranchTaken`.
- **RetiredCount:** increments by 1 on each capture whose `Wrenable` = 1 or whose `BranchResultOut` != 0. It does not increment on bubbles, stalls or flushes, and wraps from 2**32-1 to 0.
- **Reset mid-operation:**
  - A pending latched write is discarded.
  - Every register file entry is cleared to 0.
  - The counter is cleared.

## Timing

- **Reset values:** `RegA`/`RegB` = 0 (the file is all-zero), `WbRd` = 0, `WbData` = 0, `WbValid` = 0, `BranchTaken` = 0, `BranchTarget` = 0, `RetiredCount` = 0.
- **Write latency:** memory stage outputs valid before edge N are captured at N, and the register file is written at edge N+1.
  - Between N and N+1 the value is visible through the bypass.
  - From N+1 on it is visible from the register file.
- **Redirect latency:** `BranchTaken` is high in the cycle between edges N and N+1 for a branch captured at edge N.
- **Counter latency:** `RetiredCount` reflects a capture at edge N from edge N onward, i.e. it is registered together with the latch.
- **Read path:** `RegA`/`RegB` are purely combinational from `RsA`/`RsB` and the state. No added cycle.

## Structure

- **Package `wb_pkg`:**
  - `DATA_W`, `REG_ADDR_W`, `NUM_REGS`
  - `ZERO_REG` = 0
  - `wb_entry_t` packed struct {data, rd, we, br}
  - `BUBBLE` constant of type `wb_entry_t` (all zero)
- **Sub-module `reg_file`:**
  - Parameterised by `DATA_W`/`NUM_REGS`.
  - One synchronous write port, synchronous reset of all entries.
  - Two combinational read ports, with the register 0 rule inside.
- **Top level:** the latch, the bypass muxes, the branch pulse and the counter live in `wb_stage`.

## Test plan

- **Reset then write:**
  - Stimulus: release `rst`; drive `Result`=32'hDEAD_BEEF, `RdWb`=5, `Wrenable`=1 for one cycle.
  - Required response: `RegA` with `RsA`=5 reads DEAD_BEEF via the bypass in cycle 1, and from the file afterwards. `RetiredCount`=1.
- **Register 0 rule:**
  - Stimulus: write 32'h1234 to `RdWb`=0.
  - Required response: `WbValid`=0, `RegB`(`RsB`=0)=0, and `RetiredCount` still increments.
- **Branch pulse:**
  - Stimulus: `BranchResultOut`=7'd42 for one cycle, followed by `Stall` held for 3 cycles.
  - Required response: `BranchTaken` high for exactly one cycle, `BranchTarget`=42 held, `RetiredCount` +1 only.
- **Flush/Stall priority:**
  - Stimulus: assert `Flush` and `Stall` together while the inputs carry a write to r9=7.
  - Required response: the latch becomes a bubble, r9 is unchanged (0), and `WbValid`=0.
- **Reset mid-operation:**
  - Stimulus: write r3=55, then assert `rst` on the cycle the write is latched.
  - Required response: r3 reads 0, and all outputs are at their reset values.
- **Counter wrap:**
  - Stimulus: force `RetiredCount` to 32'hFFFF_FFFF via a backdoor and retire one write.
  - Required response: `RetiredCount`=0.
